// File: rtl/dm_stall_pkg.sv
// Shared types and helpers for the MEM-stage data-memory stall logic.
// Latency selection lives here so other stall sources can reuse it.
package dm_stall_pkg;

  localparam int unsigned DEF_RD_LAT = 1;
  localparam int unsigned DEF_WR_LAT = 1;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

  // Stores take priority over loads when both are flagged.
  function automatic int unsigned sel_lat(
    input logic        memread,
    input logic        memwrite,
    input int unsigned rd_lat,
    input int unsigned wr_lat
  );
    if (memwrite)
      sel_lat = wr_lat;
    else if (memread)
      sel_lat = rd_lat;
    else
      sel_lat = 0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc until the ceiling is reached
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/dm_stall_ctrl.sv
// Data-memory stall generator for the MEM stage.
// Stalls each new load/store for its latency, then lets it through.
module dm_stall_ctrl
  import dm_stall_pkg::*;
#(
  parameter int          PC_W   = 32,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned WR_LAT = DEF_WR_LAT,
  parameter int          LAT_W  = 4,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t            state;
  logic              srv_vld;
  logic [PC_W-1:0]   srv_pc;
  logic [LAT_W-1:0]  cnt;
  logic [LAT_W-1:0]  lat;
  logic              acc;
  logic              hit;
  logic              new_req;

  assign acc     = memread | memwrite;
  assign lat     = LAT_W'(sel_lat(memread, memwrite, RD_LAT, WR_LAT));
  assign hit     = srv_vld && (pc == srv_pc);
  assign new_req = acc && !hit && (lat != '0);

  // stall request: armed by a new access, held through WAIT
  always_comb begin
    busy = 1'b0;
    if (!reset && !flush) begin
      unique case (1'b1)
        (state == IDLE): busy = new_req;
        (state == WAIT): busy = acc;
      endcase
    end
  end

  // access tracking: latency countdown and served-pc memory
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      srv_vld <= 1'b0;
      srv_pc  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        srv_vld <= 1'b0;
        cnt     <= '0;
      end else if (state == IDLE) begin
        if (new_req) begin
          if (lat == LAT_W'(1)) begin
            srv_pc  <= pc;
            srv_vld <= 1'b1;
            done    <= 1'b1;
          end else begin
            cnt   <= lat - 1'b1;
            state <= WAIT;
          end
        end
      end else begin
        if (!acc) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt == LAT_W'(1)) begin
          srv_pc  <= pc;
          srv_vld <= 1'b1;
          done    <= 1'b1;
          state   <= IDLE;
          cnt     <= cnt - 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (busy),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_dm_stall_ctrl.sv
// Vector-table bench for dm_stall_ctrl across several latency setups.
// Each row drives one instance for a cycle and states its outputs.
module tb_dm_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rst_v;
  logic [4:0]  rd_v;
  logic [4:0]  wr_v;
  logic [4:0]  fl_v;
  logic [4:0]  busy_v;
  logic [4:0]  done_v;
  logic [31:0] pc_a [5];
  logic [15:0] st0, st1, st2, st3;
  logic [2:0]  st4;

  dm_stall_ctrl #(.RD_LAT(3), .WR_LAT(5)) u0 (
    .clk(clk), .reset(rst_v[0]), .pc(pc_a[0]),
    .memread(rd_v[0]), .memwrite(wr_v[0]), .flush(fl_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .stall_cycles(st0)
  );

  dm_stall_ctrl #(.RD_LAT(1), .WR_LAT(4)) u1 (
    .clk(clk), .reset(rst_v[1]), .pc(pc_a[1]),
    .memread(rd_v[1]), .memwrite(wr_v[1]), .flush(fl_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .stall_cycles(st1)
  );

  dm_stall_ctrl #(.RD_LAT(2), .WR_LAT(1)) u2 (
    .clk(clk), .reset(rst_v[2]), .pc(pc_a[2]),
    .memread(rd_v[2]), .memwrite(wr_v[2]), .flush(fl_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .stall_cycles(st2)
  );

  dm_stall_ctrl #(.RD_LAT(0), .WR_LAT(1)) u3 (
    .clk(clk), .reset(rst_v[3]), .pc(pc_a[3]),
    .memread(rd_v[3]), .memwrite(wr_v[3]), .flush(fl_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .stall_cycles(st3)
  );

  dm_stall_ctrl #(.RD_LAT(5), .WR_LAT(1), .CNT_W(3)) u4 (
    .clk(clk), .reset(rst_v[4]), .pc(pc_a[4]),
    .memread(rd_v[4]), .memwrite(wr_v[4]), .flush(fl_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .stall_cycles(st4)
  );

  typedef struct {
    int          dut;
    bit          rst;
    logic [31:0] pc;
    bit          rd;
    bit          wr;
    bit          fl;
    bit          busy;
    bit          done;
    int          st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(int d, bit rst, logic [31:0] pc,
                              bit rd, bit wr, bit fl,
                              bit b, bit dn, int st);
    vec_t v;
    v.dut = d; v.rst = rst; v.pc = pc;
    v.rd = rd; v.wr = wr; v.fl = fl;
    v.busy = b; v.done = dn; v.st = st;
    tbl.push_back(v);
  endfunction

  function automatic int get_st(int d);
    case (d)
      0: get_st = int'(st0);
      1: get_st = int'(st1);
      2: get_st = int'(st2);
      3: get_st = int'(st3);
      default: get_st = int'(st4);
    endcase
  endfunction

  task automatic check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic build();
    // u0: 3-cycle read, then a 5-cycle write flushed and replayed
    add(0, 1, 32'h0040_0010, 1, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0040_0010, 1, 0, 0, 1, 0, 0);
    add(0, 0, 32'h0040_0010, 1, 0, 0, 1, 0, 1);
    add(0, 0, 32'h0040_0010, 1, 0, 0, 1, 0, 2);
    add(0, 0, 32'h0040_0010, 1, 0, 0, 0, 1, 3);
    add(0, 0, 32'h0040_0010, 1, 0, 0, 0, 0, 3);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 3);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 4);
    add(0, 0, 32'h40, 0, 1, 1, 0, 0, 5);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 5);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 6);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 7);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 8);
    add(0, 0, 32'h40, 0, 1, 0, 1, 0, 9);
    add(0, 0, 32'h40, 0, 1, 0, 0, 1, 10);
    add(0, 0, 32'h40, 0, 1, 0, 0, 0, 10);
    // u1: write(4) then read(1), then both flags high
    add(1, 1, 32'h20, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h20, 0, 1, 0, 1, 0, 0);
    add(1, 0, 32'h20, 0, 1, 0, 1, 0, 1);
    add(1, 0, 32'h20, 0, 1, 0, 1, 0, 2);
    add(1, 0, 32'h20, 0, 1, 0, 1, 0, 3);
    add(1, 0, 32'h24, 1, 0, 0, 1, 1, 4);
    add(1, 0, 32'h24, 1, 0, 0, 0, 1, 5);
    add(1, 0, 32'h24, 1, 0, 0, 0, 0, 5);
    add(1, 0, 32'h28, 1, 1, 0, 1, 0, 5);
    add(1, 0, 32'h28, 1, 1, 0, 1, 0, 6);
    add(1, 0, 32'h28, 1, 1, 0, 1, 0, 7);
    add(1, 0, 32'h28, 1, 1, 0, 1, 0, 8);
    add(1, 0, 32'h28, 1, 1, 0, 0, 1, 9);
    // u2: served pc stays released; acc drop in WAIT abandons
    add(2, 1, 32'h30, 1, 0, 0, 0, 0, 0);
    add(2, 0, 32'h30, 1, 0, 0, 1, 0, 0);
    add(2, 0, 32'h30, 1, 0, 0, 1, 0, 1);
    add(2, 0, 32'h30, 1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++)
      add(2, 0, 32'h30, 1, 0, 0, 0, 0, 2);
    add(2, 0, 32'h34, 1, 0, 0, 1, 0, 2);
    add(2, 0, 32'h34, 0, 0, 0, 0, 0, 3);
    add(2, 0, 32'h34, 0, 0, 0, 0, 0, 3);
    add(2, 0, 32'h34, 1, 0, 0, 1, 0, 3);
    add(2, 0, 32'h34, 1, 0, 0, 1, 0, 4);
    add(2, 0, 32'h34, 1, 0, 0, 0, 1, 5);
    // u3: zero read latency never stalls
    add(3, 1, 32'h100, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(3, 0, 32'h100 + 32'(4 * i), 1, 0, 0, 0, 0, 0);
    add(3, 0, 32'h200, 0, 1, 0, 1, 0, 0);
    add(3, 0, 32'h200, 0, 1, 0, 0, 1, 1);
    // u4: 3-bit counter saturates, reset mid-WAIT
    add(4, 1, 32'h50, 1, 0, 0, 0, 0, 0);
    add(4, 0, 32'h50, 1, 0, 0, 1, 0, 0);
    add(4, 0, 32'h50, 1, 0, 0, 1, 0, 1);
    add(4, 0, 32'h50, 1, 0, 0, 1, 0, 2);
    add(4, 0, 32'h50, 1, 0, 0, 1, 0, 3);
    add(4, 0, 32'h50, 1, 0, 0, 1, 0, 4);
    add(4, 0, 32'h54, 1, 0, 0, 1, 1, 5);
    add(4, 0, 32'h54, 1, 0, 0, 1, 0, 6);
    add(4, 0, 32'h54, 1, 0, 0, 1, 0, 7);
    add(4, 1, 32'h54, 1, 0, 0, 0, 0, 7);
    add(4, 0, 32'h54, 0, 0, 0, 0, 0, 0);
    add(4, 0, 32'h54, 1, 0, 0, 1, 0, 0);
  endtask

  initial begin
    vec_t e;
    rst_v = '1;
    rd_v  = '0;
    wr_v  = '0;
    fl_v  = '0;
    for (int k = 0; k < 5; k++)
      pc_a[k] = '0;
    build();
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_v[tbl[i].dut] = tbl[i].rst;
      pc_a[tbl[i].dut]  = tbl[i].pc;
      rd_v[tbl[i].dut]  = tbl[i].rd;
      wr_v[tbl[i].dut]  = tbl[i].wr;
      fl_v[tbl[i].dut]  = tbl[i].fl;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d u%0d busy", i, e.dut),
            int'(busy_v[e.dut]), int'(e.busy));
      check($sformatf("v%0d u%0d done", i, e.dut),
            int'(done_v[e.dut]), int'(e.done));
      check($sformatf("v%0d u%0d stall_cycles", i, e.dut),
            get_st(e.dut), e.st);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
